cdc_2phase_tx: RTL and testbench



---
 rtl/cdc_pkg.sv | 15 +
 rtl/fifo_sync.sv | 57 +++++
 rtl/cdc_2phase_tx.sv | 104 ++++++++++
 tb/tb_cdc_2phase_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the 2-phase CDC transmitter: FSM encoding and
// the occupancy-counter width helper.
package cdc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with natural-wrap pointers and an explicit count register.
// Push while full and pop while empty are ignored.
module fifo_sync
  import cdc_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = level_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == LW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];
  assign level_o = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count and pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/cdc_2phase_tx.sv
// Source-domain end of a 2-phase req/ack/data link: buffers a stream and
// launches one req toggle per word, completing when the synced ack matches req.
module cdc_2phase_tx
  import cdc_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 0,
  localparam int LW = level_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic          async_req_o,
  output logic [DW-1:0] async_data_o,
  input  logic          async_ack_i,
  output logic          busy_o,
  output logic [LW-1:0] level_o,
  output logic          timeout_o,
  output state_t        state_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic                   full;
  logic                   empty;
  logic [DW-1:0]          head;
  logic                   push;
  logic                   pop;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  state_t                 state;
  logic                   req_r;
  logic [DW-1:0]          data_r;
  logic [TW-1:0]          tcnt;
  logic                   tout_r;

  // Stream handshake: a word transfers on any edge where s_valid_i and
  // s_ready_o are both high; s_ready_o depends only on reset and occupancy.
  assign s_ready_o = !rst_i && !full;
  assign push      = s_valid_i && s_ready_o;
  assign pop       = (state == ST_IDLE) && !empty;

  fifo_sync #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (s_data_i),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], async_ack_i};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // ack_s is only compared in WAIT, so stray ack toggles in IDLE are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      req_r  <= 1'b0;
      data_r <= '0;
      tcnt   <= '0;
      tout_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            data_r <= head;
            req_r  <= !req_r;
            tcnt   <= '0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_s == req_r) state <= ST_IDLE;
          if ((TIMEOUT > 0) && (tcnt != TW'(TIMEOUT))) begin
            tcnt <= tcnt + TW'(1);
            if (tcnt + TW'(1) == TW'(TIMEOUT)) tout_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign async_req_o  = req_r;
  assign async_data_o = data_r;
  assign busy_o       = (state == ST_WAIT) || !empty;
  assign timeout_o    = (TIMEOUT > 0) ? tout_r : 1'b0;
  assign state_o      = state;

endmodule

// File: tb/tb_cdc_2phase_tx.sv
// Directed bench for cdc_2phase_tx with a 2-phase receiver model and an
// expected-word queue checked as each req toggle is observed.
module tb_cdc_2phase_tx;
  import cdc_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT = 10;
  localparam int LW = level_width(DEPTH);

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          async_req;
  logic [DW-1:0] async_data;
  logic          async_ack;
  logic          busy;
  logic [LW-1:0] level;
  logic          timeout;
  state_t        state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cdc_2phase_tx #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .async_req_o (async_req),
    .async_data_o(async_data),
    .async_ack_i (async_ack),
    .busy_o      (busy),
    .level_o     (level),
    .timeout_o   (timeout),
    .state_o     (state)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // receiver model: acts 1 time unit after each negedge
  bit   ack_en = 1'b0;
  int   ack_dly = 3;
  int   ack_cyc = 0;
  int   rx_cnt = 0;
  int   spur_req = 0;
  int   spur_done = 0;
  logic seen_req;
  bit   pending;
  int   cnt;

  initial begin
    async_ack = 1'b0;
    seen_req  = 1'b0;
    pending   = 1'b0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        async_ack = 1'b0;
        seen_req  = 1'b0;
        pending   = 1'b0;
        rx_cnt    = 0;
      end else if (async_req !== seen_req) begin
        seen_req = async_req;
        pending  = 1'b1;
        cnt      = ack_dly;
        rx_cnt++;
        check("rx_word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rx_data", 32'(async_data), 32'(exp_q.pop_front()));
      end else if (spur_req != spur_done) begin
        async_ack = ~async_ack;
        spur_done = spur_req;
      end else if (pending && ack_en) begin
        if (cnt > 1) cnt--;
        else begin
          async_ack = ~async_ack;
          ack_cyc   = cyc;
          pending   = 1'b0;
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    ack_en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(s_ready), 1);
    if (s_ready) exp_q.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_clear"}, 32'(busy), 0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic r;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_req", 32'(async_req), 0);
    check("rst_data", 32'(async_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(s_ready), 1);

    // single word
    @(negedge clk);
    ack_en  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    s_valid = 1'b0;
    check("sw_no_bypass", 32'(async_req), 0);
    check("sw_level1", 32'(level), 1);
    @(negedge clk);
    check("sw_req_toggle", 32'(async_req), 1);
    check("sw_data", 32'(async_data), 32'h A5);
    check("sw_level0", 32'(level), 0);
    check("sw_busy", 32'(busy), 1);
    n = 0;
    while (busy && n < 50) begin
      check("sw_data_stable", 32'(async_data), 32'h A5);
      @(negedge clk);
      n++;
    end
    check("sw_busy_drop", 32'(busy), 0);
    check("sw_ack_to_idle", 32'(cyc - ack_cyc), SYNC_STAGES + 1);
    check("sw_rx_cnt", 32'(rx_cnt), 1);
    check("sw_level_end", 32'(level), 0);

    // burst into full, ack withheld
    do_reset();
    for (int d = 1; d <= 5; d++) push_word(8'(d));
    check("bu_level_full", 32'(level), 4);
    check("bu_ready_full", 32'(s_ready), 0);
    check("bu_req", 32'(async_req), 1);
    check("bu_inflight", 32'(async_data), 1);
    s_valid = 1'b1;
    s_data  = 8'h06;
    repeat (3) begin
      @(negedge clk);
      check("bu_hold_ready", 32'(s_ready), 0);
      check("bu_hold_level", 32'(level), 4);
    end
    ack_en = 1'b1;
    push_word(8'h06);
    wait_drain("bu");
    check("bu_rx_cnt", 32'(rx_cnt), 6);
    check("bu_final_req", 32'(async_req), 0);

    // simultaneous push and pop
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h44);
    check("pp_level2", 32'(level), 2);
    check("pp_wait", 32'(state), 32'(ST_WAIT));
    ack_en = 1'b1;
    n = 0;
    while (!(state == ST_IDLE && level == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pp_idle_seen", 32'(state), 32'(ST_IDLE));
    check("pp_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = 8'h33;
    if (s_ready) exp_q.push_back(8'h33);
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_level_same", 32'(level), 2);
    check("pp_launched", 32'(state), 32'(ST_WAIT));
    check("pp_data", 32'(async_data), 32'h 22);
    wait_drain("pp");
    check("pp_rx_cnt", 32'(rx_cnt), 4);

    // reset mid-transfer
    do_reset();
    push_word(8'h71);
    push_word(8'h72);
    push_word(8'h73);
    check("mr_level", 32'(level), 2);
    check("mr_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mr_ready_in_rst", 32'(s_ready), 0);
    @(negedge clk);
    check("mr_req", 32'(async_req), 0);
    check("mr_data", 32'(async_data), 0);
    check("mr_level0", 32'(level), 0);
    check("mr_busy0", 32'(busy), 0);
    check("mr_timeout", 32'(timeout), 0);
    check("mr_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mr_ready_after", 32'(s_ready), 1);

    // timeout
    @(negedge clk);
    ack_en = 1'b0;
    push_word(8'h5A);
    @(negedge clk);
    check("to_launch", 32'(async_req), 1);
    check("to_flag_start", 32'(timeout), 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("to_flag", 32'(timeout), 32'(k >= TIMEOUT));
    end
    ack_en = 1'b1;
    wait_drain("to");
    check("to_sticky", 32'(timeout), 1);
    check("to_rx_cnt", 32'(rx_cnt), 1);
    check("to_data", 32'(async_data), 32'h 5A);

    // spurious ack while idle and empty
    r = async_req;
    spur_req++;
    repeat (6) begin
      @(negedge clk);
      check("sp_state", 32'(state), 32'(ST_IDLE));
      check("sp_req", 32'(async_req), 32'(r));
      check("sp_busy", 32'(busy), 0);
    end
    check("sp_level", 32'(level), 0);

    // reset clears the sticky flag
    rst = 1'b1;
    @(negedge clk);
    check("end_timeout_clr", 32'(timeout), 0);
    check("end_req_clr", 32'(async_req), 0);
    rst = 1'b0;
    @(negedge clk);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
